rgb_led_scheduler: RTL and testbench

Time-shares the single 3-bit RGB LED output among up to N_REQ requesters. Each requester raises a request with its colour; the scheduler grants round-robin, holds the winner's colour for HOLD_TICKS slow ticks, then blanks for GAP_TICKS ticks before the next grant. It sits between the 1 Hz divider's tick and the RGB display pins, replacing direct drive of the LED.

---
 rtl/rgb_led_scheduler_pkg.sv | 6 +
 rtl/rgb_led_scheduler_rr.sv | 24 ++
 rtl/rgb_led_scheduler.sv | 94 +++++++++
 tb/tb_rgb_led_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rgb_led_scheduler_pkg.sv
// rgb_led_scheduler_pkg: shared state encoding and colour constants for the LED scheduler
package rgb_led_scheduler_pkg;
    localparam int COLOR_W = 3;
    localparam logic [COLOR_W-1:0] OFF = 3'b000;
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;
endpackage

// File: rtl/rgb_led_scheduler_rr.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx
);
    always_comb begin
        valid = 1'b0;
        idx = '0;
        // Scan from the farthest candidate back so the nearest one to ptr wins
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                valid = 1'b1;
                idx = IW'((int'(ptr) + k) % N_REQ);
            end
        end
        onehot = valid ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler: round-robin time-sharing of one RGB LED, show then blank, paced by a slow tick
module rgb_led_scheduler
    import rgb_led_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int HOLD_TICKS = 3,
    parameter int GAP_TICKS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [N_REQ-1:0]         req,
    input  logic [COLOR_W*N_REQ-1:0] color,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic [COLOR_W-1:0]       display,
    output logic                     busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int MAXT = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int CW = $clog2(MAXT + 1);

    state_e             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d, done_q, done_d;
    logic [COLOR_W-1:0] display_q, display_d;
    logic               busy_q, busy_d;
    logic               arb_valid;
    logic [N_REQ-1:0]   arb_onehot;
    logic [IW-1:0]      arb_idx;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req(req),
        .ptr(rr_ptr_q),
        .valid(arb_valid),
        .onehot(arb_onehot),
        .idx(arb_idx)
    );

    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d = cnt_q;
        grant_d = grant_q;
        display_d = display_q;
        done_d = '0;
        if (state_q == IDLE && arb_valid) begin
            state_d = SHOW;
            grant_d = arb_onehot;
            display_d = color[COLOR_W*arb_idx +: COLOR_W];
            cnt_d = CW'(HOLD_TICKS);
            rr_ptr_d = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end else if (state_q == SHOW && tick) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                done_d = grant_q;
                grant_d = '0;
                display_d = OFF;
                state_d = (GAP_TICKS == 0) ? IDLE : GAP;
                cnt_d = CW'(GAP_TICKS);
            end
        end else if (state_q == GAP && tick) begin
            cnt_d = cnt_q - 1'b1;
            state_d = (cnt_q == CW'(1)) ? IDLE : GAP;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            cnt_q <= '0;
            grant_q <= '0;
            done_q <= '0;
            display_q <= OFF;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q <= cnt_d;
            grant_q <= grant_d;
            done_q <= done_d;
            display_q <= display_d;
            busy_q <= busy_d;
        end
    end

    assign grant = grant_q;
    assign done = done_q;
    assign display = display_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_rgb_led_scheduler.sv
// tb_rgb_led_scheduler: directed checks of the LED scheduler with default and zero-gap instances
module tb_rgb_led_scheduler;
    logic        clk = 1'b0;
    logic        rst, tick;
    logic [3:0]  req;
    logic [11:0] color;
    logic [3:0]  grant, done, grant0, done0;
    logic [2:0]  display, display0;
    logic        busy, busy0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rgb_led_scheduler #(.N_REQ(4), .HOLD_TICKS(3), .GAP_TICKS(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .color(color),
        .grant(grant), .done(done), .display(display), .busy(busy)
    );

    rgb_led_scheduler #(.N_REQ(4), .HOLD_TICKS(3), .GAP_TICKS(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .color(color),
        .grant(grant0), .done(done0), .display(display0), .busy(busy0)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; req = '0; color = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_display", 32'(display), 0);
        chk("rst_busy", 32'(busy), 0);

        // single request with a colour change during the show
        req = 4'b0001; color = 12'h005;
        cyc();
        chk("single_grant", 32'(grant), 1);
        chk("single_display", 32'(display), 5);
        chk("single_busy", 32'(busy), 1);
        req = '0; tick = 1'b1;
        cyc();
        tick = 1'b0; color = 12'h002;
        cyc();
        chk("chg_display", 32'(display), 5);
        tick = 1'b1;
        cyc();
        chk("tick2_grant", 32'(grant), 1);
        chk("tick2_display", 32'(display), 5);
        cyc();
        tick = 1'b0;
        chk("end_done", 32'(done), 1);
        chk("end_grant", 32'(grant), 0);
        chk("end_display", 32'(display), 0);
        chk("gap_busy", 32'(busy), 1);
        cyc();
        chk("done_one_cycle", 32'(done), 0);
        chk("gap_hold_busy", 32'(busy), 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("idle_busy", 32'(busy), 0);

        // round robin over all four requesters, wrapping back to 0
        do_reset();
        req = 4'b1111; color = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("rr_grant_%0d", i), 32'(grant), 32'(1 << (i % 4)));
            chk($sformatf("rr_display_%0d", i), 32'(display), 32'((i % 4) + 1));
            tick = 1'b1;
            cyc(); cyc(); cyc();
            chk($sformatf("rr_done_%0d", i), 32'(done), 32'(1 << (i % 4)));
            cyc();
            tick = 1'b0;
            chk($sformatf("rr_idle_%0d", i), 32'(busy), 0);
        end
        req = '0;

        // tick in the grant cycle is not counted
        do_reset();
        req = 4'b0001; color = 12'h005; tick = 1'b1;
        cyc();
        req = '0;
        chk("tg_grant", 32'(grant), 1);
        cyc(); cyc();
        chk("tg_still_show", 32'(grant), 1);
        chk("tg_no_done", 32'(done), 0);
        cyc();
        chk("tg_done", 32'(done), 1);
        cyc();
        tick = 1'b0;
        chk("tg_idle", 32'(busy), 0);

        // zero gap: alternating requesters with one blank idle cycle
        do_reset();
        req = 4'b0011; color = 12'b000_000_010_001;
        cyc();
        chk("g0_grant_a", 32'(grant0), 1);
        chk("g0_display_a", 32'(display0), 1);
        tick = 1'b1;
        cyc(); cyc(); cyc();
        tick = 1'b0;
        chk("g0_done", 32'(done0), 1);
        chk("g0_idle_display", 32'(display0), 0);
        chk("g0_idle_busy", 32'(busy0), 0);
        cyc();
        chk("g0_grant_b", 32'(grant0), 2);
        chk("g0_display_b", 32'(display0), 2);
        req = '0;

        // reset during a show clears everything and the pointer
        do_reset();
        req = 4'b0100; color = 12'b000_110_000_000;
        cyc();
        req = '0;
        chk("rs_grant", 32'(grant), 4);
        chk("rs_display", 32'(display), 6);
        tick = 1'b1;
        cyc(); cyc();
        tick = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rs_grant_clr", 32'(grant), 0);
        chk("rs_display_clr", 32'(display), 0);
        chk("rs_done_clr", 32'(done), 0);
        chk("rs_busy_clr", 32'(busy), 0);
        req = 4'b1001; color = 12'b111_000_000_011;
        cyc();
        chk("rs_ptr0_grant", 32'(grant), 1);
        chk("rs_ptr0_display", 32'(display), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
